// File: rtl/pipeline_pkg.sv
// Shared helpers for the receive word-packing pipeline.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package pipeline_pkg;

  // Ceiling log2 for sizing counters and pointers (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of symbols that make up one assembled word.
  function automatic int syms(input int word_width, input int data_width);
    return word_width / data_width;
  endfunction

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head word presented from storage registers.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: a push into a full FIFO is accepted only if a pop happens on the same edge.
//
// Ports: i_clk/i_reset (sync, active high), i_push/i_push_data write side,
// i_pop read side, o_head current head, o_empty/o_full flags, o_count occupancy.
module sync_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [clog2(DEPTH+1)-1:0]    o_count
);

  localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNTW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (count == '0);
  assign o_full  = (count == CNTW'(DEPTH));
  assign o_count = count;
  assign o_head  = mem[rd_ptr];

  // When full, the slot being written is the one being popped on this edge,
  // so a simultaneous pop frees room for the push.
  assign push_ok = i_push && (!o_full || i_pop);
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs received UART symbols into words and queues them for the debug-unit FSM.
// Latency: o_word_valid rises one cycle after the final symbol strobe (empty FIFO).
// Backpressure: valid/ready toward the consumer; a word completing into a full FIFO without a pop is dropped and flagged.
//
// Ports: i_clk/i_reset (sync, active high); i_rx_done/i_rx_data symbol strobe;
// i_msb_first symbol order; i_flush drops a partial word; o_word/o_word_valid/
// i_word_ready output handshake; o_count queue depth; o_partial word in progress;
// o_timeout drop pulse; o_overflow sticky loss flag.
module rx_word_packer
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_rx_done,
  input  logic [DATA_WIDTH-1:0]             i_rx_data,
  input  logic                              i_msb_first,
  input  logic                              i_flush,
  output logic [WORD_WIDTH-1:0]             o_word,
  output logic                              o_word_valid,
  input  logic                              i_word_ready,
  output logic [clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                              o_partial,
  output logic                              o_timeout,
  output logic                              o_overflow
);

  localparam int SYMS = syms(WORD_WIDTH, DATA_WIDTH);
  localparam int CW   = (SYMS > 1) ? clog2(SYMS) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;

  asm_state_t             state;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          idle_cnt;
  logic [WORD_WIDTH-1:0]  word_reg;
  logic                   msb_hold;

  logic                   msb_eff;
  logic [CW-1:0]          slot;
  logic [WORD_WIDTH-1:0]  merged;
  logic                   accept;
  logic                   last_sym;
  logic                   push;
  logic                   pop;
  logic                   expire;
  logic                   fifo_empty;
  logic                   fifo_full;

  // The symbol order is taken live on the first symbol and held afterwards.
  always_comb begin
    msb_eff = (cnt == '0) ? i_msb_first : msb_hold;
    slot    = msb_eff ? (CW'(SYMS - 1) - cnt) : cnt;
    // A new word starts from zero so stale bytes never leak into it.
    merged  = (cnt == '0) ? '0 : word_reg;
    merged[slot*DATA_WIDTH +: DATA_WIDTH] = i_rx_data;
  end

  // A flush always beats a coincident strobe; a strobe always beats expiry.
  assign accept   = i_rx_done && !i_flush;
  assign last_sym = (cnt == CW'(SYMS - 1));
  assign push     = accept && last_sym;
  assign pop      = o_word_valid && i_word_ready;
  assign expire   = (TIMEOUT_CYCLES > 0) && (state == ASSEMBLE) && !i_rx_done &&
                    !i_flush && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign o_word_valid = !fifo_empty;
  assign o_partial    = (state == ASSEMBLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idle_cnt   <= '0;
      word_reg   <= '0;
      msb_hold   <= 1'b0;
      o_timeout  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_timeout <= expire;
      if (push && fifo_full && !pop) o_overflow <= 1'b1;

      if (i_flush) begin
        state    <= IDLE;
        cnt      <= '0;
        idle_cnt <= '0;
      end else if (accept) begin
        word_reg <= merged;
        idle_cnt <= '0;
        if (cnt == '0) msb_hold <= i_msb_first;
        if (last_sym) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= ASSEMBLE;
          cnt   <= cnt + CW'(1);
        end
      end else if (expire) begin
        state    <= IDLE;
        cnt      <= '0;
        idle_cnt <= '0;
      end else if (state == ASSEMBLE) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (merged),
    .i_pop       (pop),
    .o_head      (o_word),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full),
    .o_count     (o_count)
  );

endmodule

// File: tb/tb_rx_word_packer.sv
module tb_rx_word_packer;

  localparam int DW    = 8;
  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int SYMS  = WW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          msb_first = 1'b0;
  logic          flush = 1'b0;
  logic [WW-1:0] word;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [2:0]    count;
  logic          partial;
  logic          timeout;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  rx_word_packer #(
    .DATA_WIDTH     (DW),
    .WORD_WIDTH     (WW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_msb_first  (msb_first),
    .i_flush      (flush),
    .o_word       (word),
    .o_word_valid (word_valid),
    .i_word_ready (word_ready),
    .o_count      (count),
    .o_partial    (partial),
    .o_timeout    (timeout),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of completed words and a queue of pending symbols.
  logic [WW-1:0] mq[$];
  logic [DW-1:0] part[$];
  bit            part_msb = 1'b0;
  int            idle = 0;
  bit            m_ovf = 1'b0;
  bit            m_tmo = 1'b0;

  task automatic model_step();
    bit            do_pop;
    bit            done_word;
    logic [WW-1:0] w;
    do_pop    = (mq.size() != 0) && word_ready;
    done_word = 1'b0;
    w         = '0;
    if (rst) begin
      mq.delete();
      part.delete();
      idle  = 0;
      m_ovf = 1'b0;
      m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (flush) begin
        part.delete();
        idle = 0;
      end else if (rx_done) begin
        if (part.size() == 0) part_msb = msb_first;
        part.push_back(rx_data);
        idle = 0;
        if (part.size() == SYMS) begin
          for (int i = 0; i < SYMS; i++) begin
            if (part_msb) w[(SYMS-1-i)*DW +: DW] = part[i];
            else          w[i*DW +: DW]          = part[i];
          end
          done_word = 1'b1;
          part.delete();
        end
      end else if (part.size() != 0) begin
        idle++;
        if (idle == TMO) begin
          part.delete();
          idle  = 0;
          m_tmo = 1'b1;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (done_word) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("valid", 32'(word_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    if (mq.size() != 0) chk("word", word, mq[0]);
    chk("partial", 32'(partial), 32'(part.size() != 0));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    rx_done = 1'b1;
    rx_data = d;
    step();
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] b);
    for (int i = 0; i < 4; i++) send(b[i*8 +: 8]);
  endtask

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("reset_valid", 32'(word_valid), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_partial", 32'(partial), 0);
    chk("reset_overflow", 32'(overflow), 0);
    step();
    rst = 1'b0;

    // 1: LSB-first
    word_ready = 1'b1;
    send(8'h3C);
    @(negedge clk);
    chk("t1_partial_after_first", 32'(partial), 1);
    step();
    send(8'h3C);
    send(8'hA5);
    @(negedge clk);
    chk("t1_valid_before_last", 32'(word_valid), 0);
    step();
    send(8'hA5);
    @(negedge clk);
    chk("t1_valid", 32'(word_valid), 1);
    chk("t1_word", word, 32'hA5A5_3C3C);
    chk("t1_model_head", mq[0], 32'hA5A5_3C3C);
    chk("t1_partial_after_last", 32'(partial), 0);
    step();
    @(negedge clk);
    chk("t1_valid_one_cycle", 32'(word_valid), 0);
    step();

    // 2: MSB-first, order toggled mid-word
    msb_first = 1'b1;
    send(8'h3C);
    send(8'h3C);
    msb_first = 1'b0;
    send(8'hA5);
    send(8'hA5);
    @(negedge clk);
    chk("t2_word", word, 32'h3C3C_A5A5);
    chk("t2_model_head", mq[0], 32'h3C3C_A5A5);
    step();
    step();

    // 3: fill with no consumer, overflow on word 5, drain in order
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_word({8'(k + 8'h30), 8'(k + 8'h20), 8'(k + 8'h10), 8'(k)});
    @(negedge clk);
    chk("t3_count_full", 32'(count), 4);
    chk("t3_overflow", 32'(overflow), 1);
    step();
    word_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t3_drain_word", word, {8'(k + 8'h30), 8'(k + 8'h20), 8'(k + 8'h10), 8'(k)});
      step();
    end
    @(negedge clk);
    chk("t3_count_empty", 32'(count), 0);
    chk("t3_overflow_sticky", 32'(overflow), 1);
    step();

    // 4: timeout after two bytes
    send(8'hAA);
    send(8'hBB);
    for (int j = 0; j <= TMO; j++) begin
      @(negedge clk);
      if (j < TMO) begin
        chk("t4_no_timeout_yet", 32'(timeout), 0);
        chk("t4_partial_held", 32'(partial), 1);
      end else begin
        chk("t4_timeout_pulse", 32'(timeout), 1);
        chk("t4_partial_dropped", 32'(partial), 0);
      end
      step();
    end
    @(negedge clk);
    chk("t4_timeout_one_cycle", 32'(timeout), 0);
    step();
    send_word(32'h4433_2211);
    @(negedge clk);
    chk("t4_word", word, 32'h4433_2211);
    step();
    step();

    // 6: reset in the middle of a word
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_word", word, 0);
    chk("t6_valid", 32'(word_valid), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_partial", 32'(partial), 0);
    chk("t6_timeout", 32'(timeout), 0);
    chk("t6_overflow", 32'(overflow), 0);
    step();
    send_word(32'h1234_5678);
    @(negedge clk);
    chk("t6_word_after", word, 32'h1234_5678);
    step();
    step();

    // 5: full FIFO with a pop on the completing strobe; flush with a strobe
    word_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_word({4{8'(k)}});
    send(8'h55);
    send(8'h66);
    send(8'h77);
    rx_done    = 1'b1;
    rx_data    = 8'h88;
    word_ready = 1'b1;
    step();
    rx_done    = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    chk("t5_no_overflow", 32'(overflow), 0);
    chk("t5_count_held", 32'(count), 4);
    chk("t5_head", word, 32'h0202_0202);
    step();
    word_ready = 1'b1;
    repeat (5) step();
    send(8'hC1);
    send(8'hC2);
    rx_done = 1'b1;
    rx_data = 8'hEE;
    flush   = 1'b1;
    step();
    rx_done = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk("t5_flush_partial", 32'(partial), 0);
    step();
    send_word(32'h0403_0201);
    @(negedge clk);
    chk("t5_word_after_flush", word, 32'h0403_0201);
    chk("t5_model_after_flush", mq[0], 32'h0403_0201);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
